reg_load_sequencer: RTL and testbench

- Control-side initiator for the datapath register file and shift register: accepts 8-bit instructions over a valid/ready handshake and drives the LDA/LDB/LDO load strobes, the immediate operand bus, ALU select and shiftState.
- Sits between the instruction source (program ROM or testbench) and the register file / ALU / shifter.
- Produces exactly the one-cycle enables and multi-cycle shift commands that those registers consume.

---
 rtl/reg_load_sequencer_pkg.sv | 30 +++
 rtl/seq_down_counter.sv | 35 +++
 rtl/reg_load_sequencer.sv | 162 ++++++++++++++++
 tb/tb_reg_load_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_load_sequencer_pkg.sv
// rtl/reg_load_sequencer_pkg.sv - shared opcodes, state encoding and shift/ALU codes for reg_load_sequencer
package reg_load_sequencer_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOADA = 4'h1;
    localparam logic [3:0] OP_LOADB = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_SHLD  = 4'h5;
    localparam logic [3:0] OP_LSH   = 4'h6;
    localparam logic [3:0] OP_RSH   = 4'h7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } seq_state_t;

    localparam logic [1:0] SHIFT_HOLD = 2'b00;
    localparam logic [1:0] SHIFT_RSH  = 2'b01;
    localparam logic [1:0] SHIFT_LSH  = 2'b10;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    // Opcodes 0x8..0xF are undefined; the top bit alone separates them.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/seq_down_counter.sv
// rtl/seq_down_counter.sv - loadable down-counter with zero/one flags for the shift repeat count
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   load, load_value  load the counter (takes priority over dec)
//   dec             decrement by one; saturates at zero
//   is_zero, is_one flags decoded from the current count
module seq_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             is_zero,
    output logic             is_one
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign is_zero = (count == '0);
    assign is_one  = (count == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/reg_load_sequencer.sv
// rtl/reg_load_sequencer.sv - instruction sequencer driving register-file load strobes, ALU select and shifter control
//
// Optional feature macro: SEQ_RETIRE_COUNT_EN adds the 8-bit retired-instruction counter port.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   instr_valid, instr    instruction handshake input ([7:4] opcode, [3:0] immediate)
//   instr_ready           sequencer idle and able to accept
//   LDA, LDB, LDO         one-cycle load strobes for registers A, B and O
//   data_out              immediate for A/B and shifter data input (holds between loads)
//   alu_sel               0 = ADD, 1 = SUB, meaningful while LDO is high
//   shift_load            one-cycle shifter load strobe
//   shift_state           10 = LSH, 01 = RSH, 00 = hold
//   busy                  high while executing
//   illegal               sticky unknown-opcode flag
//   retired               (SEQ_RETIRE_COUNT_EN) wrapping count of completed instructions
module reg_load_sequencer
    import reg_load_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               instr_valid,
    input  logic [OPCODE_WIDTH+DATA_WIDTH-1:0] instr,
    output logic                               instr_ready,
    output logic                               LDA,
    output logic                               LDB,
    output logic                               LDO,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               alu_sel,
    output logic                               shift_load,
    output logic [1:0]                         shift_state,
    output logic                               busy,
    output logic                               illegal
`ifdef SEQ_RETIRE_COUNT_EN
    ,
    output logic [7:0]                         retired
`endif
);

    seq_state_t                state;
    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [DATA_WIDTH-1:0]     imm;
    logic                      accept;
    logic                      shifting;
    logic                      cnt_load;
    logic                      cnt_dec;
    logic                      cnt_zero;
    logic                      cnt_one;

    assign opcode = instr[OPCODE_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign imm    = instr[DATA_WIDTH-1:0];

    // instr_ready is a registered copy of (state == IDLE), so it is the handshake qualifier.
    assign accept   = (state == ST_IDLE) && instr_valid && instr_ready;
    // A nonzero shift_state marks a shift in progress; zero-count shifts never set it.
    assign shifting = (shift_state != SHIFT_HOLD);

    assign cnt_load = accept && ((opcode == OP_LSH) || (opcode == OP_RSH)) && (imm != '0);
    assign cnt_dec  = (state == ST_EXEC) && shifting && !cnt_zero;

    seq_down_counter #(
        .WIDTH(DATA_WIDTH)
    ) u_shift_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .load_value(imm),
        .dec       (cnt_dec),
        .is_zero   (cnt_zero),
        .is_one    (cnt_one)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            instr_ready <= 1'b1;
            LDA         <= 1'b0;
            LDB         <= 1'b0;
            LDO         <= 1'b0;
            data_out    <= '0;
            alu_sel     <= ALU_ADD;
            shift_load  <= 1'b0;
            shift_state <= SHIFT_HOLD;
            busy        <= 1'b0;
            illegal     <= 1'b0;
`ifdef SEQ_RETIRE_COUNT_EN
            retired     <= 8'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        // Decode straight from instr on the handshake edge so the
                        // strobes are already registered in the first EXEC cycle.
                        state       <= ST_EXEC;
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        case (opcode)
                            OP_NOP: ;
                            OP_LOADA: begin
                                LDA      <= 1'b1;
                                data_out <= imm;
                            end
                            OP_LOADB: begin
                                LDB      <= 1'b1;
                                data_out <= imm;
                            end
                            OP_ADD: begin
                                LDO     <= 1'b1;
                                alu_sel <= ALU_ADD;
                            end
                            OP_SUB: begin
                                LDO     <= 1'b1;
                                alu_sel <= ALU_SUB;
                            end
                            OP_SHLD: begin
                                shift_load <= 1'b1;
                                data_out   <= imm;
                            end
                            OP_LSH: begin
                                if (imm != '0) shift_state <= SHIFT_LSH;
                            end
                            OP_RSH: begin
                                if (imm != '0) shift_state <= SHIFT_RSH;
                            end
                            default: begin
                                if (is_illegal_op(opcode[3:0])) illegal <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    // Shifts stay while the counter is above one; it was loaded
                    // with n, so shift_state is held for exactly n cycles.
                    if (!(shifting && !cnt_one)) begin
                        state       <= ST_IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        LDA         <= 1'b0;
                        LDB         <= 1'b0;
                        LDO         <= 1'b0;
                        alu_sel     <= ALU_ADD;
                        shift_load  <= 1'b0;
                        shift_state <= SHIFT_HOLD;
`ifdef SEQ_RETIRE_COUNT_EN
                        retired     <= retired + 8'd1;
`endif
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_load_sequencer.sv
// tb/tb_reg_load_sequencer.sv - scoreboard testbench for reg_load_sequencer
module tb_reg_load_sequencer;

    typedef struct packed {
        logic       lda;
        logic       ldb;
        logic       ldo;
        logic       alu;
        logic       sl;
        logic [1:0] ss;
        logic [3:0] d;
        logic       ill;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       instr_ready, LDA, LDB, LDO, alu_sel, shift_load, busy, illegal;
    logic [3:0] data_out;
    logic [1:0] shift_state;
`ifdef SEQ_RETIRE_COUNT_EN
    logic [7:0] retired;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;
    rec_t q[$];
    logic [3:0] exp_data = 4'h0;
    logic       exp_ill  = 1'b0;

    always #5 clk = ~clk;

    reg_load_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .LDA        (LDA),
        .LDB        (LDB),
        .LDO        (LDO),
        .data_out   (data_out),
        .alu_sel    (alu_sel),
        .shift_load (shift_load),
        .shift_state(shift_state),
        .busy       (busy),
        .illegal    (illegal)
`ifdef SEQ_RETIRE_COUNT_EN
        ,
        .retired    (retired)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: each busy cycle consumes one expected record; idle cycles must be quiet.
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) begin
                if (q.size() == 0) begin
                    chk("unexpected_busy", 32'(busy), 32'd0);
                end else begin
                    rec_t e, a;
                    e = q.pop_front();
                    a = '{lda: LDA, ldb: LDB, ldo: LDO, alu: alu_sel, sl: shift_load,
                          ss: shift_state, d: data_out, ill: illegal};
                    if (!e.ldo) a.alu = e.alu;
                    chk("exec_outputs", 32'(a), 32'(e));
                    chk("exec_ready_low", 32'(instr_ready), 32'd0);
                end
            end else if (!reset) begin
                chk("idle_quiet", {26'd0, instr_ready, LDA, LDB, LDO, shift_load, |shift_state}, 32'h20);
            end
        end
    end

    // Push the expected EXEC-cycle outputs for v, then perform the handshake.
    task automatic send(input logic [7:0] v, input bit keep_valid);
        int   t;
        rec_t r;
        logic [3:0] op, n;
        op = v[7:4];
        n  = v[3:0];
        t  = 0;
        while (!instr_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!instr_ready) chk("ready_timeout", 32'(instr_ready), 32'd1);
        r = '0;
        case (op)
            4'h1: begin exp_data = n; r.lda = 1'b1; end
            4'h2: begin exp_data = n; r.ldb = 1'b1; end
            4'h3: begin r.ldo = 1'b1; r.alu = 1'b0; end
            4'h4: begin r.ldo = 1'b1; r.alu = 1'b1; end
            4'h5: begin exp_data = n; r.sl = 1'b1; end
            4'h6: r.ss = (n != 0) ? 2'b10 : 2'b00;
            4'h7: r.ss = (n != 0) ? 2'b01 : 2'b00;
            4'h0: ;
            default: exp_ill = 1'b1;
        endcase
        r.d   = exp_data;
        r.ill = exp_ill;
        if ((op == 4'h6 || op == 4'h7) && n != 0) begin
            for (int i = 0; i < int'(n); i++) q.push_back(r);
        end else begin
            q.push_back(r);
        end
        instr       = v;
        instr_valid = 1'b1;
        @(negedge clk);
        if (!keep_valid) instr_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || busy) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        // Reset state while reset is held.
        chk("reset_ready", 32'(instr_ready), 32'd1);
        chk("reset_outs", {23'd0, LDA, LDB, LDO, shift_load, shift_state, busy, illegal, alu_sel},
            32'd0);
        chk("reset_data", 32'(data_out), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Single LOADA, then ready returns and LDA drops.
        send(8'h1A, 1'b0);
        @(negedge clk);
        chk("loada_after_ready", 32'(instr_ready), 32'd1);
        chk("loada_after_lda", 32'(LDA), 32'd0);

        // Back-to-back with valid held high.
        send(8'h13, 1'b1);
        send(8'h25, 1'b1);
        send(8'h30, 1'b1);
        instr_valid = 1'b0;
        drain();

        send(8'h44, 1'b0);
        send(8'h5C, 1'b0);
        send(8'h63, 1'b0);
        send(8'h70, 1'b0);
        drain();
        chk("data_hold", 32'(data_out), 32'hC);

        // Illegal opcode is sticky across a following NOP.
        send(8'h9F, 1'b0);
        send(8'h00, 1'b0);
        drain();
        chk("illegal_sticky", 32'(illegal), 32'd1);

        // Reset on the fourth cycle of a 15-step right shift.
        send(8'h7F, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_ss", 32'(shift_state), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ready", 32'(instr_ready), 32'd1);
        chk("rst_mid_illegal", 32'(illegal), 32'd0);
        chk("rst_mid_consumed", 32'(q.size()), 32'd11);
        q.delete();
        exp_ill  = 1'b0;
        exp_data = 4'h0;

        // Reset and valid together: nothing accepted.
        instr       = 8'h1A;
        instr_valid = 1'b1;
        @(negedge clk);
        chk("rst_wins_busy", 32'(busy), 32'd0);
        chk("rst_wins_lda", 32'(LDA), 32'd0);
        instr_valid = 1'b0;
        reset       = 1'b0;
        @(negedge clk);
        chk("rst_wins_after", 32'(busy), 32'd0);

        send(8'h27, 1'b0);
        drain();

`ifdef SEQ_RETIRE_COUNT_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        exp_ill  = 1'b0;
        exp_data = 4'h0;
        for (int i = 0; i < 257; i++) send(8'h00, 1'b0);
        drain();
        chk("retired_wrap", 32'(retired), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
